// File: rtl/gen_pack_pkg.sv
// Shared helpers for the width-up packer: lane-mask generation and staging-lane insert.
// Helpers work on fixed maximum widths so any DAT_W/RATIO instance can slice the result.
package gen_pack_pkg;

    localparam int unsigned MAX_DAT_W = 32;
    localparam int unsigned MAX_LANES = 32;
    localparam int unsigned MAX_STG_W = 256;

    // Mask with the low 'fill' lanes set.
    function automatic logic [MAX_LANES-1:0] msk_from_fill(input int unsigned fill);
        logic [MAX_LANES-1:0] msk;
        if (fill >= MAX_LANES) begin
            msk = {MAX_LANES{1'b1}};
        end else begin
            msk = (MAX_LANES'(1'b1) << fill) - MAX_LANES'(1'b1);
        end
        return msk;
    endfunction

    // Overwrite lane 'lane' of width dat_w inside the staging vector.
    function automatic logic [MAX_STG_W-1:0] lane_insert(
        input logic [MAX_STG_W-1:0] stg,
        input int unsigned          lane,
        input int unsigned          dat_w,
        input logic [MAX_DAT_W-1:0] dat
    );
        logic [MAX_STG_W-1:0] lane_msk;
        lane_msk = ((MAX_STG_W'(1'b1) << dat_w) - MAX_STG_W'(1'b1)) << (lane * dat_w);
        return (stg & ~lane_msk) | ((MAX_STG_W'(dat) << (lane * dat_w)) & lane_msk);
    endfunction

endpackage

// File: rtl/gen_fifo_pack.sv
// Width-up packer: pops DAT_W words from a same-cycle FIFO read port and emits RATIO-word
// beats on a valid/ready port with lane mask; flush emits a partial beat.
module gen_fifo_pack
    import gen_pack_pkg::*;
#(
    parameter int unsigned DAT_W = 4,
    parameter int unsigned RATIO = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fifo_empty,
    input  logic [DAT_W-1:0]         fifo_dat,
    output logic                     fifo_pop,
    input  logic                     flush,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [DAT_W*RATIO-1:0]   out_dat,
    output logic [RATIO-1:0]         out_msk,
    output logic                     out_last,
    output logic [$clog2(RATIO)-1:0] sts_fill
);

    localparam int unsigned OUT_W = DAT_W * RATIO;
    localparam int unsigned IDX_W = $clog2(RATIO);
    localparam int unsigned STG_W = DAT_W * (RATIO - 1);

    logic [STG_W-1:0] stg_r;
    logic [IDX_W-1:0] idx_r;
    logic             flush_pend_r;
    logic             out_vld_r;
    logic [OUT_W-1:0] out_dat_r;
    logic [RATIO-1:0] out_msk_r;
    logic             out_last_r;

    logic             out_free_s;
    logic             pop_s;
    logic             flush_req_s;
    logic [STG_W-1:0] stg_nxt_s;
    logic [IDX_W-1:0] idx_nxt_s;
    logic             flush_pend_nxt_s;
    logic             out_vld_nxt_s;
    logic [OUT_W-1:0] out_dat_nxt_s;
    logic [RATIO-1:0] out_msk_nxt_s;
    logic             out_last_nxt_s;

    // Pop/flush arbitration and next-state of staging and output register.
    always_comb begin
        out_free_s       = ~out_vld_r | out_rdy;
        pop_s            = ~fifo_empty & out_free_s & ~flush & ~flush_pend_r;
        flush_req_s      = flush | flush_pend_r;
        stg_nxt_s        = stg_r;
        idx_nxt_s        = idx_r;
        flush_pend_nxt_s = flush_pend_r;
        out_vld_nxt_s    = out_vld_r & ~out_rdy;
        out_dat_nxt_s    = out_dat_r;
        out_msk_nxt_s    = out_msk_r;
        out_last_nxt_s   = out_last_r;
        if (pop_s) begin
            if (idx_r == IDX_W'(RATIO - 1)) begin
                out_dat_nxt_s  = {fifo_dat, stg_r};
                out_msk_nxt_s  = {RATIO{1'b1}};
                out_last_nxt_s = 1'b0;
                out_vld_nxt_s  = 1'b1;
                stg_nxt_s      = {STG_W{1'b0}};
                idx_nxt_s      = {IDX_W{1'b0}};
            end else begin
                stg_nxt_s = STG_W'(lane_insert(MAX_STG_W'(stg_r), 32'(idx_r), DAT_W,
                                               MAX_DAT_W'(fifo_dat)));
                idx_nxt_s = idx_r + IDX_W'(1'b1);
            end
        end else if (flush_req_s) begin
            if (out_free_s) begin
                flush_pend_nxt_s = 1'b0;
                if (idx_r != {IDX_W{1'b0}}) begin
                    // Unused staging lanes are already zero, so no extra masking is needed.
                    out_dat_nxt_s  = {{DAT_W{1'b0}}, stg_r};
                    out_msk_nxt_s  = RATIO'(msk_from_fill(32'(idx_r)));
                    out_last_nxt_s = 1'b1;
                    out_vld_nxt_s  = 1'b1;
                    stg_nxt_s      = {STG_W{1'b0}};
                    idx_nxt_s      = {IDX_W{1'b0}};
                end else begin
                    stg_nxt_s = stg_r;
                end
            end else begin
                flush_pend_nxt_s = 1'b1;
            end
        end else begin
            flush_pend_nxt_s = flush_pend_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_r        <= {STG_W{1'b0}};
            idx_r        <= {IDX_W{1'b0}};
            flush_pend_r <= 1'b0;
            out_vld_r    <= 1'b0;
            out_dat_r    <= {OUT_W{1'b0}};
            out_msk_r    <= {RATIO{1'b0}};
            out_last_r   <= 1'b0;
        end else begin
            stg_r        <= stg_nxt_s;
            idx_r        <= idx_nxt_s;
            flush_pend_r <= flush_pend_nxt_s;
            out_vld_r    <= out_vld_nxt_s;
            out_dat_r    <= out_dat_nxt_s;
            out_msk_r    <= out_msk_nxt_s;
            out_last_r   <= out_last_nxt_s;
        end
    end

    assign fifo_pop = pop_s;
    assign out_vld  = out_vld_r;
    assign out_dat  = out_dat_r;
    assign out_msk  = out_msk_r;
    assign out_last = out_last_r;
    assign sts_fill = idx_r;

endmodule

// File: tb/tb_gen_fifo_pack.sv
// Directed bench for gen_fifo_pack (DAT_W=4, RATIO=4) with a behavioural zero-delay FIFO.
module tb_gen_fifo_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_empty;
    logic [3:0]  fifo_dat;
    logic        fifo_pop;
    logic        flush;
    logic        out_vld;
    logic        out_rdy;
    logic [15:0] out_dat;
    logic [3:0]  out_msk;
    logic        out_last;
    logic [1:0]  sts_fill;

    logic [3:0]  mem [0:63];
    logic [5:0]  wr_ptr = 6'd0;
    logic [5:0]  rd_ptr = 6'd0;

    int n_vec = 0;
    int n_err = 0;

    gen_fifo_pack #(.DAT_W(4), .RATIO(4)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dat(fifo_dat),
        .fifo_pop(fifo_pop), .flush(flush), .out_vld(out_vld), .out_rdy(out_rdy),
        .out_dat(out_dat), .out_msk(out_msk), .out_last(out_last), .sts_fill(sts_fill)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_dat   = mem[rd_ptr];

    always @(posedge clk) begin
        if (fifo_pop) rd_ptr <= rd_ptr + 6'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] d);
        mem[wr_ptr] = d;
        wr_ptr      = wr_ptr + 6'd1;
    endtask

    task automatic chk_beat(input string tag, input logic [15:0] d, input logic [3:0] m,
                            input logic l);
        chk({tag, "_vld"},  32'(out_vld), 32'd1);
        chk({tag, "_dat"},  32'(out_dat), 32'(d));
        chk({tag, "_msk"},  32'(out_msk), 32'(m));
        chk({tag, "_last"}, 32'(out_last), 32'(l));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_rdy = 1'b1;
        @(negedge clk);
        chk("rst_vld", 32'(out_vld), 32'd0);
        chk("rst_dat", 32'(out_dat), 32'd0);
        chk("rst_msk", 32'(out_msk), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_fill", 32'(sts_fill), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Full beats, eight consecutive pops.
        for (int i = 1; i <= 8; i++) push(4'(i));
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("full_pop", 32'(fifo_pop), 32'd1);
            @(negedge clk);
            if (i == 3) chk_beat("full_b0", 16'h4321, 4'hF, 1'b0);
            if (i == 4) chk("full_retire", 32'(out_vld), 32'd0);
            if (i == 7) chk_beat("full_b1", 16'h8765, 4'hF, 1'b0);
        end
        chk("empty_nopop", 32'(fifo_pop), 32'd0);
        @(negedge clk);
        chk("full_vld_off", 32'(out_vld), 32'd0);

        // Flush partial beat.
        push(4'hA); push(4'hB);
        repeat (2) @(negedge clk);
        chk("fp_fill", 32'(sts_fill), 32'd2);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk_beat("fp", 16'h00BA, 4'b0011, 1'b1);
        chk("fp_fill0", 32'(sts_fill), 32'd0);
        @(negedge clk);
        chk("fp_retire", 32'(out_vld), 32'd0);

        // Flush with nothing staged: no beat, no lingering pend.
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("f0_novld", 32'(out_vld), 32'd0);
        push(4'h5);
        #1;
        chk("f0_pop", 32'(fifo_pop), 32'd1);
        @(negedge clk);
        chk("f0_fill", 32'(sts_fill), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk_beat("f1", 16'h0005, 4'b0001, 1'b1);
        @(negedge clk);

        // Backpressure after the first beat.
        for (int i = 1; i <= 8; i++) push(4'(i));
        repeat (4) @(negedge clk);
        chk_beat("bp_b0", 16'h4321, 4'hF, 1'b0);
        out_rdy = 1'b0;
        #1;
        chk("bp_nopop", 32'(fifo_pop), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_dat", 32'(out_dat), 32'h4321);
            chk("bp_hold_pop", 32'(fifo_pop), 32'd0);
            chk("bp_hold_fill", 32'(sts_fill), 32'd0);
        end
        out_rdy = 1'b1;
        #1;
        chk("bp_resume", 32'(fifo_pop), 32'd1);
        repeat (3) @(negedge clk);
        chk("bp_fill3", 32'(sts_fill), 32'd3);
        chk("bp_vld0", 32'(out_vld), 32'd0);
        @(negedge clk);
        chk_beat("bp_b1", 16'h8765, 4'hF, 1'b0);
        @(negedge clk);

        // Flush beating a simultaneous pop, then flush absorbed under backpressure.
        push(4'h1); push(4'h2); push(4'h5); push(4'h6);
        repeat (2) @(negedge clk);
        chk("fs_fill2", 32'(sts_fill), 32'd2);
        flush = 1'b1; out_rdy = 1'b0;
        #1;
        chk("fs_pop_supp", 32'(fifo_pop), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        chk_beat("fs", 16'h0021, 4'b0011, 1'b1);
        chk("fs_fill0", 32'(sts_fill), 32'd0);
        chk("fs_bp_pop", 32'(fifo_pop), 32'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk_beat("fs_hold", 16'h0021, 4'b0011, 1'b1);
        out_rdy = 1'b1;
        #1;
        chk("fs_pend_pop", 32'(fifo_pop), 32'd0);
        @(negedge clk);
        chk("fs_nobeat", 32'(out_vld), 32'd0);
        chk("fs_resume", 32'(fifo_pop), 32'd1);
        repeat (2) @(negedge clk);
        chk("fs_fill_r", 32'(sts_fill), 32'd2);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk_beat("fs_tail", 16'h0065, 4'b0011, 1'b1);
        @(negedge clk);

        // Mid-operation reset with three words staged.
        push(4'h1); push(4'h2); push(4'h3);
        repeat (3) @(negedge clk);
        chk("mr_fill3", 32'(sts_fill), 32'd3);
        rst = 1'b1;
        #1;
        chk("mr_fill", 32'(sts_fill), 32'd0);
        chk("mr_vld", 32'(out_vld), 32'd0);
        chk("mr_dat", 32'(out_dat), 32'd0);
        chk("mr_msk", 32'(out_msk), 32'd0);
        chk("mr_last", 32'(out_last), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        push(4'h9); push(4'hA); push(4'hB); push(4'hC);
        repeat (3) @(negedge clk);
        chk("mr_novld", 32'(out_vld), 32'd0);
        @(negedge clk);
        chk_beat("mr_b0", 16'hCBA9, 4'hF, 1'b0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gen_fifo_pack.md
# gen_fifo_pack

Width-up packer sitting directly downstream of the zero-delay FIFO. It pops DAT_W-wide words from the FIFO's same-cycle read port and packs RATIO consecutive words into one OUT_W-wide beat. Beats leave on a valid/ready interface with a lane mask. A flush request emits a partially filled beat, so the packer never strands data when the FIFO runs dry at a frame boundary.

## Interface
- DAT_W, 4, FIFO word width [bits]
- RATIO, 4, words per output beat; legal range is RATIO >= 2
- OUT_W (localparam), DAT_W*RATIO, output beat width
- IDX_W (localparam), $clog2(RATIO), lane index width

Ports:
- clk  in  1  clock
- rst  in  1  reset; **one clock; reset is asynchronous and active-high**
- fifo_empty  in  1  FIFO sts_empty
- fifo_dat  in  DAT_W  FIFO dat_out; valid in the same cycle as ~fifo_empty
- fifo_pop  out  1  FIFO pop
- flush  in  1  single-cycle request to emit the partial beat
- out_vld  out  1  output beat valid
- out_rdy  in  1  downstream ready
- out_dat  out  OUT_W  packed beat; lane 0 (first word) occupies the LSBs
- out_msk  out  RATIO  lane-valid mask
- out_last  out  1  beat was produced by a flush
- sts_fill  out  IDX_W  number of words currently staged (0..RATIO-1)

## Operation
- Reset values: out_vld=0, out_dat=0, out_msk=0, out_last=0, sts_fill=0, flush_pend=0, staging=0.
- out_free = ~out_vld | out_rdy.
- Pop rule: fifo_pop = ~fifo_empty & out_free & ~flush & ~flush_pend.
  - fifo_pop is purely combinational.
  - fifo_pop is never asserted while fifo_empty, so the FIFO never sees an underflow.
- Staging registers:
  - RATIO-1 lanes of DAT_W each, plus the fill index idx (exported as sts_fill).
  - On a pop with idx < RATIO-1: write fifo_dat into lane idx, then idx++.
- Beat completion, on a pop with idx == RATIO-1:
  - output register loads {fifo_dat, staged lanes RATIO-2..0};
  - out_msk = all ones, out_last = 0, out_vld = 1;
  - idx wraps to 0 and staging is zeroed.
- Flush:
  - flush, or a pending flush, with out_free and idx > 0: the output register loads the staged lanes with unused lanes zeroed.
  - In that case out_msk = (1<<idx)-1, out_last = 1, out_vld = 1, idx = 0, flush_pend = 0.
  - flush with ~out_free: set flush_pend and hold it until out_free.
  - flush with idx == 0: no beat is emitted and flush_pend clears.
  - flush during flush_pend: absorbed, no second beat.
  - Flush covers only words already popped; it never drains the FIFO.
- Output hold: while out_vld & ~out_rdy, out_dat, out_msk and out_last must be held stable.
- Beat retirement: out_vld drops on out_vld & out_rdy unless a new beat loads in the same cycle.
- Reset mid-operation: staged words and any pending beat are discarded. No beat is emitted after reset deassertion until RATIO new pops, or a pop followed by a flush.

## Timing
- Pop-to-beat latency: last word popped in cycle N gives out_vld=1 in cycle N+1.
- Flush latency: flush in cycle N with out_free gives the beat in N+1. When the beat is delayed, it appears in the cycle after out_free first holds.
- Throughput:
  - with fifo_empty=0 and out_rdy=1, one beat every RATIO cycles and no bubbles;
  - a completing pop and the acceptance of the previous beat may occur in the same cycle.
- Simultaneous flush and non-empty FIFO: flush wins and the pop is suppressed that cycle. Popping resumes the cycle after the flush beat loads.
- Backpressure: with out_rdy=0 and out_vld=1, fifo_pop=0 and sts_fill is frozen. Backpressure therefore propagates into the FIFO, whose count grows.

## Structure
- Shared package gen_pack_pkg holds:
  - the lane-mask function msk_from_fill(idx) returning RATIO bits;
  - the lane-insert function for the staging array.
- Single flat module, no sub-module. The control is idx, flush_pend and out_vld; a separate FSM is not warranted.
- The output register is a one-entry valid/ready stage. gen_skid_buff_top is not instantiated: zero-bubble backpressure into the FIFO is already handled by the pop rule.

## Test plan
- Full beats: RATIO=4, DAT_W=4, FIFO preloaded with 1,2,3,4,5,6,7,8, out_rdy=1.
  - Required: beat 0x4321 msk=1111 last=0, then 0x8765 four cycles later; pops on 8 consecutive cycles.
- Flush partial: push 0xA,0xB and let the FIFO empty, then pulse flush.
  - Required: next cycle out_dat=0x00BA, msk=0011, last=1, sts_fill returns to 0.
- Flush with nothing staged: flush with idx=0.
  - Required: no out_vld; flush_pend=0 the following cycle.
- Backpressure: out_rdy=0 after the first beat with 8 words queued.
  - Required: out_dat held at 0x4321, fifo_pop=0, sts_fill frozen.
  - After out_rdy=1: 0x8765 follows with no lost or duplicated word.
- Flush under backpressure plus simultaneous pop:
  - Stimulus: flush while out_vld=1, out_rdy=0, idx=2, FIFO non-empty.
  - Required: pop suppressed; partial beat (msk=0011, last=1) appears the cycle after out_rdy rises; popping then resumes.
- Mid-operation reset: assert rst with idx=3 and a pending beat.
  - Required: all outputs are at their reset values within the same cycle.
  - Required: the first beat after reset contains only post-reset words.
